// File: rtl/ttc_intr_sched8.sv
// ttc_intr_sched8
// Round-robin interrupt scheduler for the timer/counter channels. Picks one
// enabled, requesting channel, presents its id and status snapshot to the CPU,
// pulses that channel's clear on acknowledge, and gives up on the grant if the
// CPU never answers. A short holdoff after each clear or timeout lets the
// channel's clear settle before the next arbitration.

module ttc_intr_sched8 #(
    parameter int NUM_CH      = 3,
    parameter int CH_W        = 2,
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                pclk8,
    input  logic                n_p_reset8,
    input  logic [NUM_CH-1:0]   irq_req8,
    input  logic [6*NUM_CH-1:0] irq_status8,
    input  logic                mask_wr8,
    input  logic [NUM_CH-1:0]   mask_wdata8,
    input  logic                cpu_ack8,
    output logic                cpu_irq8,
    output logic [CH_W-1:0]     cpu_vec8,
    output logic [5:0]          cpu_status8,
    output logic [NUM_CH-1:0]   clear_interrupt8,
    output logic                timeout8,
    output logic [NUM_CH-1:0]   mask_out8
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_ACK,
        S_CLEAR,
        S_HOLD
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   winner_q;
    logic [TO_W-1:0]   to_cnt;
    logic [HC_W-1:0]   hold_cnt;
    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   rr_winner;
    logic              rr_found;

    assign eligible = irq_req8 & mask_out8;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        int cand;
        rr_found  = 1'b0;
        rr_winner = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!rr_found && eligible[cand]) begin
                rr_found  = 1'b1;
                rr_winner = CH_W'(cand);
            end
        end
    end

    // Scheduler FSM, enable mask and all registered outputs
    always_ff @(posedge pclk8) begin
        if (!n_p_reset8) begin
            state            <= S_IDLE;
            rr_ptr           <= CH_W'(NUM_CH - 1);
            winner_q         <= '0;
            to_cnt           <= '0;
            hold_cnt         <= '0;
            mask_out8        <= '0;
            cpu_irq8         <= 1'b0;
            cpu_vec8         <= '0;
            cpu_status8      <= '0;
            clear_interrupt8 <= '0;
            timeout8         <= 1'b0;
        end else begin
            if (mask_wr8) begin
                mask_out8 <= mask_wdata8;
            end
            clear_interrupt8 <= '0;
            timeout8         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rr_found) begin
                        winner_q <= rr_winner;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    cpu_vec8    <= winner_q;
                    cpu_status8 <= irq_status8[int'(winner_q)*6 +: 6];
                    rr_ptr      <= winner_q;
                    to_cnt      <= '0;
                    cpu_irq8    <= 1'b1;
                    state       <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (cpu_ack8) begin
                        cpu_irq8         <= 1'b0;
                        clear_interrupt8 <= NUM_CH'(1) << cpu_vec8;
                        state            <= S_CLEAR;
                    end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        cpu_irq8 <= 1'b0;
                        timeout8 <= 1'b1;
                        hold_cnt <= '0;
                        state    <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CLEAR: begin
                    hold_cnt <= '0;
                    state    <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttc_intr_sched8.sv
// tb_ttc_intr_sched8
// Directed bench for the interrupt scheduler. Stimulus pushes the expected
// grants, clears and timeouts into queues; a monitor pops and compares them
// whenever the scheduler presents one.

module tb_ttc_intr_sched8;

    logic        pclk8;
    logic        n_p_reset8;
    logic [2:0]  irq_req8;
    logic [17:0] irq_status8;
    logic        mask_wr8;
    logic [2:0]  mask_wdata8;
    logic        cpu_ack8;
    logic        cpu_irq8;
    logic [1:0]  cpu_vec8;
    logic [5:0]  cpu_status8;
    logic [2:0]  clear_interrupt8;
    logic        timeout8;
    logic [2:0]  mask_out8;

    typedef struct packed {
        logic [1:0] vec;
        logic [5:0] status;
    } grant_t;

    grant_t     expGrantQ[$];
    logic [2:0] expClearQ[$];
    int         expTimeoutQ[$];

    int   checks = 0;
    int   errors = 0;
    logic prevIrq = 1'b0;

    ttc_intr_sched8 #(
        .NUM_CH(3),
        .CH_W(2),
        .ACK_TIMEOUT(4),
        .TO_W(2),
        .HOLD_CYCLES(2)
    ) dut (
        .pclk8(pclk8),
        .n_p_reset8(n_p_reset8),
        .irq_req8(irq_req8),
        .irq_status8(irq_status8),
        .mask_wr8(mask_wr8),
        .mask_wdata8(mask_wdata8),
        .cpu_ack8(cpu_ack8),
        .cpu_irq8(cpu_irq8),
        .cpu_vec8(cpu_vec8),
        .cpu_status8(cpu_status8),
        .clear_interrupt8(clear_interrupt8),
        .timeout8(timeout8),
        .mask_out8(mask_out8)
    );

    // Free-running clock
    initial begin
        pclk8 = 1'b0;
        forever #5 pclk8 = ~pclk8;
    end

    // Hard stop in case the run never reaches its summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk8);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [17:0] status);
        irq_req8    = req;
        irq_status8 = status;
    endtask

    task automatic writeMask(input logic [2:0] m);
        mask_wr8    = 1'b1;
        mask_wdata8 = m;
        tick(1);
        mask_wr8    = 1'b0;
    endtask

    task automatic waitIrq(input string name, input int maxCycles);
        int n;
        n = 0;
        while (!cpu_irq8 && n < maxCycles) begin
            tick(1);
            n++;
        end
        checkOutput(name, 32'(cpu_irq8), 32'd1);
    endtask

    task automatic ackOnce();
        cpu_ack8 = 1'b1;
        tick(1);
        cpu_ack8 = 1'b0;
    endtask

    // Scoreboard monitor: compares every grant, clear pulse and timeout pulse
    always @(negedge pclk8) begin
        if (cpu_irq8 === 1'b1 && prevIrq !== 1'b1) begin
            if (expGrantQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_grant: got vec %0d, expected no grant", cpu_vec8);
            end else begin
                grant_t g;
                g = expGrantQ.pop_front();
                checkOutput("grant_vec", 32'(cpu_vec8), 32'(g.vec));
                checkOutput("grant_status", 32'(cpu_status8), 32'(g.status));
            end
        end
        prevIrq = cpu_irq8;
        if (clear_interrupt8 !== 3'b000 && clear_interrupt8 !== 3'bxxx) begin
            if (expClearQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_clear: got %b, expected none", clear_interrupt8);
            end else begin
                checkOutput("clear_onehot", 32'(clear_interrupt8), 32'(expClearQ.pop_front()));
            end
        end
        if (timeout8 === 1'b1) begin
            if (expTimeoutQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_timeout: got 1, expected 0");
            end else begin
                checkOutput("timeout_pulse", 32'd1, 32'(expTimeoutQ.pop_front()));
            end
        end
    end

    // Directed test sequence
    initial begin
        logic sawIrq;
        int   highCycles;
        grant_t g;

        n_p_reset8  = 1'b0;
        irq_req8    = 3'b000;
        irq_status8 = '0;
        mask_wr8    = 1'b0;
        mask_wdata8 = 3'b000;
        cpu_ack8    = 1'b0;
        tick(3);

        // Test 1: reset values, masked requests never granted
        checkOutput("rst_irq", 32'(cpu_irq8), 32'd0);
        checkOutput("rst_vec", 32'(cpu_vec8), 32'd0);
        checkOutput("rst_status", 32'(cpu_status8), 32'd0);
        checkOutput("rst_clear", 32'(clear_interrupt8), 32'd0);
        checkOutput("rst_timeout", 32'(timeout8), 32'd0);
        checkOutput("rst_mask", 32'(mask_out8), 32'd0);
        n_p_reset8 = 1'b1;
        applyStimulus(3'b111, {6'h33, 6'h22, 6'h11});
        sawIrq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            sawIrq = sawIrq | cpu_irq8;
        end
        checkOutput("t1_masked_irq", 32'(sawIrq), 32'd0);
        checkOutput("t1_mask_out", 32'(mask_out8), 32'd0);
        applyStimulus(3'b000, '0);

        // Test 2: single channel, latency, one-cycle clear, two hold cycles
        writeMask(3'b111);
        checkOutput("t2_mask_out", 32'(mask_out8), 32'h7);
        g.vec = 2'd1; g.status = 6'h05;
        expGrantQ.push_back(g);
        applyStimulus(3'b010, {6'h00, 6'h05, 6'h00});
        tick(1);
        checkOutput("t2_lat_edge1", 32'(cpu_irq8), 32'd0);
        tick(1);
        checkOutput("t2_lat_edge2", 32'(cpu_irq8), 32'd1);
        expClearQ.push_back(3'b010);
        ackOnce();
        checkOutput("t2_clear", 32'(clear_interrupt8), 32'h2);
        checkOutput("t2_irq_drop", 32'(cpu_irq8), 32'd0);
        expGrantQ.push_back(g);
        tick(1);
        checkOutput("t2_clear_1cyc", 32'(clear_interrupt8), 32'd0);
        checkOutput("t2_vec_hold", 32'(cpu_vec8), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_holdoff", 32'(cpu_irq8), 32'd0);
            tick(1);
        end
        checkOutput("t2_holdoff", 32'(cpu_irq8), 32'd0);
        tick(1);
        checkOutput("t2_regrant", 32'(cpu_irq8), 32'd1);
        expClearQ.push_back(3'b010);
        ackOnce();
        applyStimulus(3'b000, '0);
        tick(4);

        // Test 3: all requesting, round-robin order 0,1,2,0 from reset
        n_p_reset8 = 1'b0;
        tick(1);
        n_p_reset8 = 1'b1;
        checkOutput("t3_rst_mask", 32'(mask_out8), 32'd0);
        writeMask(3'b111);
        g.vec = 2'd0; g.status = 6'h11; expGrantQ.push_back(g); expClearQ.push_back(3'b001);
        g.vec = 2'd1; g.status = 6'h22; expGrantQ.push_back(g); expClearQ.push_back(3'b010);
        g.vec = 2'd2; g.status = 6'h33; expGrantQ.push_back(g); expClearQ.push_back(3'b100);
        g.vec = 2'd0; g.status = 6'h11; expGrantQ.push_back(g); expClearQ.push_back(3'b001);
        applyStimulus(3'b111, {6'h33, 6'h22, 6'h11});
        for (int i = 0; i < 4; i++) begin
            waitIrq("t3_irq", 10);
            ackOnce();
        end
        applyStimulus(3'b000, {6'h33, 6'h22, 6'h11});
        tick(4);

        // Test 4: no ack, timeout after 4 cycles, then round-robin moves past ch0
        g.vec = 2'd0; g.status = 6'h11; expGrantQ.push_back(g);
        expTimeoutQ.push_back(1);
        applyStimulus(3'b001, {6'h33, 6'h22, 6'h11});
        waitIrq("t4_irq", 10);
        highCycles = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!cpu_irq8) break;
            highCycles++;
        end
        checkOutput("t4_irq_len", 32'(highCycles), 32'd4);
        checkOutput("t4_timeout", 32'(timeout8), 32'd1);
        checkOutput("t4_no_clear", 32'(clear_interrupt8), 32'd0);
        g.vec = 2'd1; g.status = 6'h22; expGrantQ.push_back(g);
        applyStimulus(3'b011, {6'h33, 6'h22, 6'h11});
        tick(1);
        checkOutput("t4_timeout_1cyc", 32'(timeout8), 32'd0);
        waitIrq("t4_next_irq", 10);
        expClearQ.push_back(3'b010);
        ackOnce();
        applyStimulus(3'b000, {6'h33, 6'h22, 6'h11});
        checkOutput("t4_clear", 32'(clear_interrupt8), 32'h2);
        tick(4);

        // Test 5: ack on the final timeout cycle wins over the timeout
        g.vec = 2'd2; g.status = 6'h33; expGrantQ.push_back(g);
        applyStimulus(3'b100, {6'h33, 6'h22, 6'h11});
        waitIrq("t5_irq", 10);
        tick(3);
        checkOutput("t5_last_cycle", 32'(cpu_irq8), 32'd1);
        expClearQ.push_back(3'b100);
        ackOnce();
        applyStimulus(3'b000, {6'h33, 6'h22, 6'h11});
        checkOutput("t5_clear", 32'(clear_interrupt8), 32'h4);
        checkOutput("t5_no_timeout", 32'(timeout8), 32'd0);
        tick(1);
        checkOutput("t5_no_timeout_late", 32'(timeout8), 32'd0);
        tick(3);

        // Test 6: reset aborts a grant; mask cleared mid-grant lets it finish
        g.vec = 2'd1; g.status = 6'h22; expGrantQ.push_back(g);
        applyStimulus(3'b010, {6'h33, 6'h22, 6'h11});
        waitIrq("t6_irq", 10);
        n_p_reset8 = 1'b0;
        tick(1);
        checkOutput("t6_rst_irq", 32'(cpu_irq8), 32'd0);
        checkOutput("t6_rst_clear", 32'(clear_interrupt8), 32'd0);
        checkOutput("t6_rst_vec", 32'(cpu_vec8), 32'd0);
        n_p_reset8 = 1'b1;
        applyStimulus(3'b000, {6'h33, 6'h22, 6'h11});
        tick(1);
        checkOutput("t6_rst_no_clear", 32'(clear_interrupt8), 32'd0);
        writeMask(3'b111);
        g.vec = 2'd0; g.status = 6'h11; expGrantQ.push_back(g);
        applyStimulus(3'b111, {6'h33, 6'h22, 6'h11});
        waitIrq("t6_post_rst_irq", 10);
        writeMask(3'b000);
        checkOutput("t6_grant_kept", 32'(cpu_irq8), 32'd1);
        checkOutput("t6_mask_zero", 32'(mask_out8), 32'd0);
        expClearQ.push_back(3'b001);
        ackOnce();
        checkOutput("t6_clear", 32'(clear_interrupt8), 32'h1);
        sawIrq = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            sawIrq = sawIrq | cpu_irq8;
        end
        checkOutput("t6_no_regrant", 32'(sawIrq), 32'd0);

        // Everything expected must have been observed
        tick(2);
        checkOutput("grant_q_empty", 32'(expGrantQ.size()), 32'd0);
        checkOutput("clear_q_empty", 32'(expClearQ.size()), 32'd0);
        checkOutput("timeout_q_empty", 32'(expTimeoutQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
